// File: rtl/seq_gen_fsm.sv
// ---------------------------------------------------------------------------
// seq_gen_fsm
//
// Serial pattern generator. On an accepted start it captures a bit pattern,
// an effective length and an effective repetition count. It then shifts the
// pattern out MSB-first (bit len-1 down to 0), one bit per clock, for the
// requested number of repetitions. A single-cycle done pulse follows the last
// bit, and then the block returns to idle. All outputs are registered.
//
// Optional feature (macro SEQ_GEN_GAP_EN):
//   When the macro is defined, one idle "gap" cycle (out=0, valid=0, busy=1)
//   separates consecutive repetitions. There is no gap after the final one.
//   When the macro is undefined, repetitions run back-to-back and no gap
//   state exists.
//
// Parameters:
//   MAXLEN   maximum pattern length in bits (2..16)
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset (priority over start)
//   start    begin request, sampled only while idle
//   pattern  bit pattern, captured on start acceptance
//   len      bits to send; 0/1 -> 1, > MAXLEN -> MAXLEN
//   reps     repetition count; 0 -> 1
//   out      registered serial bit
//   valid    out carries a pattern bit
//   busy     transmission in progress (including gap cycles)
//   done     one-cycle completion pulse
// ---------------------------------------------------------------------------
module seq_gen_fsm #(
  parameter int unsigned MAXLEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [4:0]        len,
  input  logic [3:0]        reps,
  output logic              out,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IdxW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [4:0]  MaxLen5 = 5'(MAXLEN);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2,
    StGap   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  // Effective length minus one, i.e. the index of the first (MSB) bit sent.
  logic [IdxW-1:0]   len_m1_q, len_m1_d;
  // Index of the bit currently presented on out.
  logic [IdxW-1:0]   idx_q, idx_d;
  // Repetitions still to start after the current one. Counting down to zero
  // avoids wrap with reps=15.
  logic [3:0]        reps_left_q, reps_left_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Input clamping, applied only at start acceptance.
  logic [4:0]      len_clamp;
  logic [IdxW-1:0] len_clamp_m1;
  logic [3:0]      reps_m1;

  always_comb begin
    if (len <= 5'd1) begin
      len_clamp = 5'd1;
    end else if (len > MaxLen5) begin
      len_clamp = MaxLen5;
    end else begin
      len_clamp = len;
    end
    len_clamp_m1 = IdxW'(len_clamp - 5'd1);
    reps_m1      = (reps == 4'd0) ? 4'd0 : (reps - 4'd1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_m1_d    = len_m1_q;
    idx_d       = idx_q;
    reps_left_d = reps_left_q;
    out_d       = 1'b0;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d       = pattern;
          len_m1_d    = len_clamp_m1;
          idx_d       = len_clamp_m1;
          reps_left_d = reps_m1;
          // The first bit is presented in the very cycle after acceptance.
          out_d       = pattern[len_clamp_m1];
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = StShift;
        end
      end

      StShift: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          idx_d   = idx_q - IdxW'(1);
          out_d   = pat_q[idx_q - IdxW'(1)];
          valid_d = 1'b1;
        end else if (reps_left_q != 4'd0) begin
          reps_left_d = reps_left_q - 4'd1;
`ifdef SEQ_GEN_GAP_EN
          state_d = StGap;
`else
          idx_d   = len_m1_q;
          out_d   = pat_q[len_m1_q];
          valid_d = 1'b1;
`endif
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end

`ifdef SEQ_GEN_GAP_EN
      StGap: begin
        idx_d   = len_m1_q;
        out_d   = pat_q[len_m1_q];
        valid_d = 1'b1;
        busy_d  = 1'b1;
        state_d = StShift;
      end
`endif

      StDone: begin
        idx_d       = '0;
        reps_left_d = 4'd0;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_m1_q    <= '0;
      idx_q       <= '0;
      reps_left_q <= 4'd0;
      out_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_m1_q    <= len_m1_d;
      idx_q       <= idx_d;
      reps_left_q <= reps_left_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifndef SYNTHESIS
  a_valid_implies_busy: assert property (@(posedge clk) disable iff (rst) valid |-> busy);
  a_done_quiet: assert property (@(posedge clk) disable iff (rst) done |-> (!busy && !valid));
  a_done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);
`endif

endmodule

// File: tb/tb_seq_gen_fsm.sv
// ---------------------------------------------------------------------------
// tb_seq_gen_fsm
//
// Self-checking bench for seq_gen_fsm (MAXLEN=8). Each transaction is checked
// cycle by cycle against an expected output stream built from the behavioural
// rules: MSB-first bits, repeated reps_eff times, with optional gap cycles, a
// done cycle and then idle. A table of directed vectors, hand-written reset
// sequences and a block of random transactions drive the checks.
// ---------------------------------------------------------------------------
module tb_seq_gen_fsm;

  localparam int unsigned MaxLen = 8;
`ifdef SEQ_GEN_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [MaxLen-1:0] pattern;
  logic [4:0]        len;
  logic [3:0]        reps;
  logic              out;
  logic              valid;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_gen_fsm #(
    .MAXLEN (MaxLen)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [4:0] l);
    if (l <= 5'd1) return 1;
    if (int'(l) > int'(MaxLen)) return int'(MaxLen);
    return int'(l);
  endfunction

  function automatic int eff_reps(input logic [3:0] r);
    return (r == 4'd0) ? 1 : int'(r);
  endfunction

  // Runs one transaction and checks {out,valid,busy,done} every cycle from
  // acceptance to the idle cycle after done. With hold set, start stays high
  // and the data inputs are scrambled throughout.
  task automatic run_txn(input logic [7:0] p, input logic [4:0] l, input logic [3:0] r,
                         input bit hold, output int nvalid, output int ndet,
                         output logic first_bit);
    logic [3:0] exp_q[$];
    logic [2:0] hist;
    int         le;
    int         re;
    le = eff_len(l);
    re = eff_reps(r);
    for (int k = 0; k < re; k++) begin
      for (int i = le - 1; i >= 0; i--) exp_q.push_back({p[i], 1'b1, 1'b1, 1'b0});
      if (GapEn && (k < re - 1)) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);

    nvalid    = 0;
    ndet      = 0;
    hist      = 3'b000;
    first_bit = 1'b0;

    @(negedge clk);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;

    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      check($sformatf("stream[%0d] p=%0h l=%0d r=%0d", c, p, l, r),
            32'({out, valid, busy, done}), 32'(exp_q[c]));
      if (valid) begin
        nvalid++;
        if (nvalid == 1) first_bit = out;
        hist = {hist[1:0], out};
        if (nvalid >= 3 && hist == 3'b101) ndet++;
      end
      if (hold) begin
        pattern = 8'($urandom);
        len     = 5'($urandom);
        reps    = 4'($urandom);
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [4:0] len;
    logic [3:0] reps;
    bit         hold;
    int         exp_valid;
    logic       exp_first;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    int   nvalid;
    int   ndet;
    logic first_bit;
    logic [7:0] rp;
    logic [4:0] rl;
    logic [3:0] rr;
    bit         rh;

    vecs[0] = '{pat: 8'h05, len: 5'd3,  reps: 4'd2,  hold: 1'b0, exp_valid: 6,   exp_first: 1'b1};
    vecs[1] = '{pat: 8'h01, len: 5'd0,  reps: 4'd0,  hold: 1'b0, exp_valid: 1,   exp_first: 1'b1};
    vecs[2] = '{pat: 8'hA5, len: 5'd31, reps: 4'd15, hold: 1'b0, exp_valid: 120, exp_first: 1'b1};
    vecs[3] = '{pat: 8'h0E, len: 5'd1,  reps: 4'd3,  hold: 1'b0, exp_valid: 3,   exp_first: 1'b0};
    vecs[4] = '{pat: 8'h3C, len: 5'd8,  reps: 4'd1,  hold: 1'b1, exp_valid: 8,   exp_first: 1'b0};
    vecs[5] = '{pat: 8'h80, len: 5'd9,  reps: 4'd0,  hold: 1'b0, exp_valid: 8,   exp_first: 1'b1};
    vecs[6] = '{pat: 8'h02, len: 5'd2,  reps: 4'd15, hold: 1'b1, exp_valid: 30,  exp_first: 1'b1};

    rst     = 1'b1;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({out, valid, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'({out, valid, busy, done}), 32'd0);

    // Reset wins over start; idle must persist once reset is released.
    pattern = 8'hFF;
    len     = 5'd8;
    reps    = 4'd1;
    rst     = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    check("rst_priority", 32'({out, valid, busy, done}), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_priority_idle", 32'({out, valid, busy, done}), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].pat, vecs[v].len, vecs[v].reps, vecs[v].hold, nvalid, ndet, first_bit);
      check($sformatf("valid_count[%0d]", v), 32'(nvalid), 32'(vecs[v].exp_valid));
      check($sformatf("first_bit[%0d]", v), 32'(first_bit), 32'(vecs[v].exp_first));
      if (v == 0) check("detect_101", 32'(ndet), 32'd2);
    end

    // Reset during the third bit of an 8-bit transmission.
    @(negedge clk);
    pattern = 8'hFF;
    len     = 5'd8;
    reps    = 4'd1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mid_first_bit", 32'({out, valid, busy, done}), 32'b1110);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", 32'({out, valid, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'({out, valid, busy, done}), 32'd0);
    run_txn(8'h5A, 5'd4, 4'd2, 1'b0, nvalid, ndet, first_bit);
    check("post_reset_count", 32'(nvalid), 32'd8);

    for (int t = 0; t < 25; t++) begin
      rp = 8'($urandom);
      rl = 5'($urandom_range(0, 31));
      rr = 4'($urandom_range(0, 15));
      rh = 1'($urandom_range(0, 1));
      run_txn(rp, rl, rr, rh, nvalid, ndet, first_bit);
      check($sformatf("rand_count[%0d]", t), 32'(nvalid), 32'(eff_len(rl) * eff_reps(rr)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen_fsm.md
SEQ_GEN_FSM -- requirements
Module: seq_gen_fsm

Interface
REQ-001 SHALL have parameter MAXLEN, default 8, meaning the maximum pattern length in bits (range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to begin transmission, sampled only in IDLE.
REQ-005 SHALL have port pattern, input, MAXLEN, the bit pattern to transmit, captured on start acceptance.
REQ-006 SHALL have port len, input, 5, the number of pattern bits to send; 0 or 1 is treated as 1, and values above MAXLEN are treated as MAXLEN.
REQ-007 SHALL have port reps, input, 4, the repetition count; 0 is treated as 1.
REQ-008 SHALL have port out, output, 1, the registered serial bit stream.
REQ-009 SHALL have port valid, output, 1, high in every cycle where out carries a pattern bit.
REQ-010 SHALL have port busy, output, 1, high from start acceptance through the last bit or gap.
REQ-011 SHALL have port done, output, 1, a single-cycle completion pulse.

Function
REQ-012 SHALL implement the states IDLE, SHIFT, GAP and DONE, with all outputs registered (Moore).
REQ-013 In IDLE with start=1, on that edge the block SHALL capture pattern, clamped len and clamped reps, drive out to pattern[len-1], set valid=1 and busy=1, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL present the next lower bit: MSB-first order, bit index len-1 down to 0, with exactly one bit per cycle.
REQ-015 After bit 0 is presented, if repetitions remain, the next edge SHALL restart at bit len-1 (or enter GAP, see REQ-022); otherwise it SHALL enter DONE.
REQ-016 In DONE, out=0, valid=0, busy=0 and done=1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-017 start SHALL be ignored in SHIFT, GAP and DONE; captured values SHALL NOT change mid-transmission even if the inputs change.
REQ-018 Total valid cycles SHALL equal len_eff*reps_eff; done SHALL occur in the cycle after the last valid bit.
REQ-019 The internal bit index and repetition counters SHALL NOT wrap: reps=15 with len=MAXLEN SHALL produce exactly 15*MAXLEN bits.
REQ-020 In IDLE, out=0, valid=0, busy=0 and done=0.

Reset
REQ-021 When rst=1 at an edge, in any state including mid-transmission, the block SHALL enter IDLE with out=0, valid=0, busy=0, done=0 and cleared counters; rst SHALL take priority over start.

Configuration
REQ-022 Macro SEQ_GEN_GAP_EN:
- When defined, one GAP cycle (out=0, valid=0, busy=1) SHALL be inserted between consecutive repetitions.
- No GAP cycle follows the final repetition.
- When not defined, repetitions SHALL be back-to-back, and the GAP state SHALL be absent.

Verification
REQ-023 Back-to-back repetitions (gap off): pattern=3'b101, len=3, reps=2, with start pulsed for one cycle -> out=1,0,1,1,0,1 with valid=1 for 6 cycles, then done=1 in cycle 7. Feeding this stream to the team's 101 overlapping detector SHALL yield 2 detections.
REQ-024 Gap inserted (SEQ_GEN_GAP_EN defined), same stimulus as REQ-023 -> out=1,0,1,(gap: valid=0),1,0,1, then done in cycle 8; busy=1 during the gap.
REQ-025 Zero clamping: len=0, reps=0, pattern[0]=1 -> a single valid cycle with out=1, then done; no hang.
REQ-026 Input isolation: start held high and pattern changed during SHIFT -> the transmitted bits match the originally captured pattern; no restart occurs after done until IDLE is re-entered.
REQ-027 Reset mid-transmission: rst asserted at bit 2 of len=8 -> on the next cycle out=0, valid=0, busy=0, done=0; a new start is then accepted normally.
REQ-028 Maximum counts: len=31 (clamped to MAXLEN=8), reps=15, pattern=8'hA5 -> exactly 120 valid cycles repeating 10100101, then one done pulse.
